// File: rtl/pwm_capture_if.sv
// Measurement result bundle for pwm_capture.
//   duty_out  : last measured duty (high cycles per period), held between updates
//   valid_out : one-cycle pulse when duty_out is updated
//   err_out   : one-cycle pulse on period mismatch or stuck-high line
//   lock_out  : high while the last reported event was a valid measurement
// master drives the results (the capture block), slave consumes them.
interface pwm_capture_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] duty_out;
  logic             valid_out;
  logic             err_out;
  logic             lock_out;

  modport master (
    output duty_out,
    output valid_out,
    output err_out,
    output lock_out
  );

  modport slave (
    input duty_out,
    input valid_out,
    input err_out,
    input lock_out
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM duty-cycle capture. Synchronises an asynchronous PWM line, frames periods between
// successive rising edges and reports the high-time of every period whose length matches
// the nominal 2**WIDTH cycles. A line that stops toggling is reported after 2*PERIOD
// cycles and then every PERIOD cycles: low -> duty 0 measurement, high -> error.
//   clk_in   : single clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   pwm_in   : PWM line, asynchronous to clk_in
//   meas     : result bundle (duty_out, valid_out, err_out, lock_out), master side
// SYNC must be at least 2.
module pwm_capture #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SYNC  = 2
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          pwm_in,
  pwm_capture_if.master meas
);

  localparam int unsigned CntW = WIDTH + 2;
  localparam logic [CntW-1:0] Period = CntW'(1) << WIDTH;
  // Timeout fires on the update that would bring T to 2*PERIOD.
  localparam logic [CntW-1:0] TimeoutLast = (Period << 1) - CntW'(1);

  typedef enum logic [0:0] {StAcq, StRun} state_e;

  logic [SYNC-1:0]  sync_q;
  logic             s;
  logic             s_d_q;
  logic             rise;
  state_e           state_q;
  logic [CntW-1:0]  p_q;
  logic [CntW-1:0]  h_q;
  logic [CntW-1:0]  t_q;
  logic [WIDTH-1:0] duty_q;
  logic             valid_q;
  logic             err_q;
  logic             lock_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], pwm_in};
    end
  end

  assign s    = sync_q[SYNC-1];
  assign rise = s & ~s_d_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s_d_q   <= 1'b0;
      state_q <= StAcq;
      p_q     <= '0;
      h_q     <= '0;
      t_q     <= '0;
      duty_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      s_d_q   <= s;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (rise) begin
        // A rise always opens a new period; it only reports if a previous one was framed.
        // Taking this branch first also lets a rise suppress a coincident timeout.
        p_q     <= CntW'(1);
        h_q     <= CntW'(1);
        t_q     <= CntW'(1);
        state_q <= StRun;
        if (state_q == StRun) begin
          if (p_q == Period) begin
            // H <= PERIOD-1 here since a rise needs a preceding low cycle.
            duty_q  <= h_q[WIDTH-1:0];
            valid_q <= 1'b1;
            lock_q  <= 1'b1;
          end else begin
            err_q  <= 1'b1;
            lock_q <= 1'b0;
          end
        end
      end else if (t_q == TimeoutLast) begin
        // Reload to PERIOD so a stuck line repeats its report every PERIOD cycles.
        t_q     <= Period;
        state_q <= StAcq;
        if (s) begin
          err_q  <= 1'b1;
          lock_q <= 1'b0;
        end else begin
          duty_q  <= '0;
          valid_q <= 1'b1;
          lock_q  <= 1'b1;
        end
      end else begin
        t_q <= t_q + CntW'(1);
        if (state_q == StRun) begin
          p_q <= p_q + CntW'(1);
          if (s) begin
            h_q <= h_q + CntW'(1);
          end
        end
      end
    end
  end

  assign meas.duty_out  = duty_q;
  assign meas.valid_out = valid_q;
  assign meas.err_out   = err_q;
  assign meas.lock_out  = lock_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed PWM waveforms, an event-level reference model that
// derives reports from rise-to-rise spans and timeout deadlines, per-cycle output
// comparison and a few hand-computed pins per scenario.
module tb_pwm_capture;

  localparam int WIDTH  = 4;
  localparam int SYNC   = 2;
  localparam int PERIOD = 1 << WIDTH;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b1;
  logic pwm_in   = 1'b0;

  pwm_capture_if #(.WIDTH(WIDTH)) meas ();

  pwm_capture #(
    .WIDTH(WIDTH),
    .SYNC (SYNC)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .pwm_in  (pwm_in),
    .meas    (meas)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Model state: pwm sample per clock edge since reset release, framing and deadline.
  bit pw [0:4095];
  int n;
  bit framed;
  int last_rise;
  int deadline;
  bit e_valid, e_err, e_lock;
  int e_duty;

  // Per-scenario observations of the DUT.
  int seg_valid, seg_err, first_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (edge %0d): got %0d expected %0d", name, n, act, exp);
    end
  endtask

  // Synchronised line value as seen by the capture logic at edge k.
  function automatic bit sval(input int k);
    if (k - SYNC >= 1) return pw[k - SYNC];
    return 1'b0;
  endfunction

  task automatic model_reset();
    n        = 0;
    framed   = 1'b0;
    last_rise = 0;
    deadline = 2 * PERIOD;
    e_valid  = 1'b0;
    e_err    = 1'b0;
    e_lock   = 1'b0;
    e_duty   = 0;
  endtask

  task automatic model_edge();
    bit s, sd;
    int hi;
    s       = sval(n);
    sd      = sval(n - 1);
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (s && !sd) begin
      if (framed) begin
        hi = 0;
        for (int k = last_rise; k < n; k++) hi += int'(sval(k));
        if (n - last_rise == PERIOD) begin
          e_valid = 1'b1;
          e_duty  = hi;
          e_lock  = 1'b1;
        end else begin
          e_err  = 1'b1;
          e_lock = 1'b0;
        end
      end
      framed    = 1'b1;
      last_rise = n;
      deadline  = n + 2 * PERIOD - 1;
    end else if (n == deadline) begin
      if (s) begin
        e_err  = 1'b1;
        e_lock = 1'b0;
      end else begin
        e_valid = 1'b1;
        e_duty  = 0;
        e_lock  = 1'b1;
      end
      framed   = 1'b0;
      deadline = n + PERIOD;
    end
  endtask

  task automatic seg_clear();
    seg_valid   = 0;
    seg_err     = 0;
    first_valid = -1;
  endtask

  // One clock: drive, let the edge happen, advance the model, compare on the falling edge.
  task automatic step(input bit v);
    pwm_in = v;
    @(posedge clk_in);
    n++;
    pw[n] = v;
    model_edge();
    @(negedge clk_in);
    chk("valid_out", meas.valid_out, e_valid);
    chk("err_out", meas.err_out, e_err);
    chk("duty_out", meas.duty_out, e_duty);
    chk("lock_out", meas.lock_out, e_lock);
    chk("valid_err_exclusive", meas.valid_out & meas.err_out, 0);
    if (meas.valid_out) begin
      seg_valid++;
      if (first_valid < 0) first_valid = n;
    end
    if (meas.err_out) seg_err++;
  endtask

  task automatic periods(input int hi, input int cnt, input int len);
    for (int c = 0; c < cnt; c++) begin
      for (int i = 0; i < len; i++) step(i < hi);
    end
  endtask

  // Assert reset away from any clock edge, confirm the outputs clear at once, release.
  task automatic do_reset();
    @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    chk("rst_duty", meas.duty_out, 0);
    chk("rst_valid", meas.valid_out, 0);
    chk("rst_err", meas.err_out, 0);
    chk("rst_lock", meas.lock_out, 0);
    @(posedge clk_in);
    @(negedge clk_in);
    pwm_in   = 1'b0;
    rst_n_in = 1'b1;
    model_reset();
    seg_clear();
  endtask

  initial begin
    model_reset();
    seg_clear();

    // Line held low from reset: duty 0 reported at edge 32, then every 16.
    do_reset();
    for (int i = 0; i < 50; i++) step(1'b0);
    chk("low_first_valid", first_valid, 32);
    chk("low_valid_count", seg_valid, 2);
    chk("low_lock", meas.lock_out, 1);

    // Ideal duty 10: first rise only frames, valid closes each later period.
    do_reset();
    periods(10, 6, PERIOD);
    chk("ideal_first_valid", first_valid, 19);
    chk("ideal_valid_count", seg_valid, 5);
    chk("ideal_err_count", seg_err, 0);
    chk("ideal_duty", meas.duty_out, 10);

    // Duty sweep 1..15, three periods each.
    seg_clear();
    for (int d = 1; d < PERIOD; d++) periods(d, 3, PERIOD);
    chk("sweep_err_count", seg_err, 0);
    chk("sweep_valid_count", seg_valid, 45);
    chk("sweep_final_duty", meas.duty_out, 15);

    // One 17-cycle period in an otherwise ideal stream.
    seg_clear();
    periods(10, 1, PERIOD + 1);
    periods(10, 3, PERIOD);
    chk("stretch_err_count", seg_err, 1);
    chk("stretch_valid_count", seg_valid, 3);
    chk("stretch_duty", meas.duty_out, 10);
    chk("stretch_lock", meas.lock_out, 1);

    // Line stuck high: closing valid, then errors 31, 47, 63 edges after the rise.
    seg_clear();
    for (int i = 0; i < 70; i++) step(1'b1);
    chk("stuck_valid_count", seg_valid, 1);
    chk("stuck_err_count", seg_err, 3);
    chk("stuck_duty_held", meas.duty_out, 10);
    chk("stuck_lock", meas.lock_out, 0);

    // Recover, then reset mid-period while locked.
    seg_clear();
    periods(10, 4, PERIOD);
    chk("recover_err_count", seg_err, 1);
    chk("recover_valid_count", seg_valid, 2);
    chk("recover_lock", meas.lock_out, 1);
    for (int i = 0; i < 5; i++) step(1'b1);
    do_reset();
    periods(10, 3, PERIOD);
    chk("post_rst_first_valid", first_valid, 19);
    chk("post_rst_valid_count", seg_valid, 2);
    chk("post_rst_duty", meas.duty_out, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
